// File: rtl/calc_operand_entry.sv
// Keypad operand entry: accumulates decimal digits into SRC/DST, latches the
// operator, issues it to the ALU over valid/ready and reloads SRC from RESULT.
module calc_operand_entry #(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4,
    parameter int OPW        = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         key_valid,
    input  logic [1:0]   key_kind,
    input  logic [3:0]   key_val,
    input  logic         op_ready,
    input  logic         result_valid,
    input  logic [W-1:0] RESULT,
    output logic [W-1:0] SRC,
    output logic [W-1:0] DST,
    output logic [7:0]   ALU_OP,
    output logic         op_valid,
    output logic [W-1:0] disp_value,
    output logic         ovf,
    output logic         key_drop,
    output logic [1:0]   state
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] DEC_LIMIT = pow10(MAX_DIGITS) - 64'd1;

    generate
        if (MAX_DIGITS < 1 || W > 60 || DEC_LIMIT >= (64'd1 << W)) begin : g_bad_digits
            $error("calc_operand_entry: 10^MAX_DIGITS-1 does not fit in W bits");
        end
        if (OPW < 1 || OPW > 8) begin : g_bad_opw
            $error("calc_operand_entry: OPW must be 1..8");
        end
    endgenerate

    localparam int              CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]   CMAX    = CW'(MAX_DIGITS);
    localparam logic [7:0]      OP_MASK = 8'((9'd1 << OPW) - 9'd1);
    localparam logic [1:0]      K_DIG = 2'd0, K_OP = 2'd1, K_EQ = 2'd2, K_CTL = 2'd3;

    typedef enum logic [1:0] {S_SRC = 2'd0, S_DST = 2'd1, S_ISSUE = 2'd2, S_WAIT = 2'd3} st_t;

    st_t           st;
    logic [CW-1:0] scnt, dcnt;
    logic          fresh;

    logic          entering, is_dst, dig_ok, is_clr, is_bksp, wr_en;
    logic [W-1:0]  cur_opd, wr_val;
    logic [CW-1:0] cur_cnt, wr_cnt;
    logic [W+3:0]  x10;

    // Shared edit path for whichever operand is being entered.
    always_comb begin
        entering = (st == S_SRC) || (st == S_DST);
        is_dst   = (st == S_DST);
        cur_opd  = is_dst ? DST : SRC;
        cur_cnt  = is_dst ? dcnt : scnt;
        dig_ok   = key_valid && key_kind == K_DIG && key_val <= 4'd9;
        is_clr   = key_valid && key_kind == K_CTL && key_val == 4'd0;
        is_bksp  = key_valid && key_kind == K_CTL && key_val == 4'd1;
        x10      = {4'b0, cur_opd} * (W+4)'(10) + (W+4)'(key_val);
        wr_en    = 1'b0;
        wr_val   = cur_opd;
        wr_cnt   = cur_cnt;
        if (entering && dig_ok && fresh) begin
            wr_en  = 1'b1;
            wr_val = W'(key_val);
            wr_cnt = CW'(1);
        end else if (entering && dig_ok && cur_cnt < CMAX) begin
            wr_en  = 1'b1;
            wr_val = x10[W-1:0];
            wr_cnt = cur_cnt + CW'(1);
        end else if (entering && is_bksp && cur_cnt != '0) begin
            wr_en  = 1'b1;
            wr_val = cur_opd / W'(10);
            wr_cnt = cur_cnt - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            SRC      <= '0;
            DST      <= '0;
            ALU_OP   <= '0;
            op_valid <= 1'b0;
            ovf      <= 1'b0;
            key_drop <= 1'b0;
            scnt     <= '0;
            dcnt     <= '0;
            fresh    <= 1'b0;
            st       <= S_SRC;
        end else begin
            ovf      <= 1'b0;
            key_drop <= 1'b0;
            // Clear beats everything, including a handshake or result on the same edge.
            if (is_clr) begin
                SRC      <= '0;
                DST      <= '0;
                ALU_OP   <= '0;
                op_valid <= 1'b0;
                scnt     <= '0;
                dcnt     <= '0;
                fresh    <= 1'b0;
                st       <= S_SRC;
            end else begin
                if (wr_en) begin
                    if (is_dst) begin
                        DST  <= wr_val;
                        dcnt <= wr_cnt;
                    end else begin
                        SRC  <= wr_val;
                        scnt <= wr_cnt;
                    end
                end
                case (st)
                    S_SRC, S_DST: begin
                        if (key_valid) begin
                            case (key_kind)
                                K_DIG: begin
                                    if (key_val > 4'd9) key_drop <= 1'b1;
                                    else if (fresh)     fresh    <= 1'b0;
                                    else if (!wr_en)    ovf      <= 1'b1;
                                end
                                K_OP: begin
                                    ALU_OP <= {4'b0, key_val} & OP_MASK;
                                    if (!is_dst) begin
                                        DST   <= '0;
                                        dcnt  <= '0;
                                        fresh <= 1'b0;
                                        st    <= S_DST;
                                    end
                                end
                                K_EQ: begin
                                    if (is_dst) begin
                                        op_valid <= 1'b1;
                                        st       <= S_ISSUE;
                                    end else begin
                                        key_drop <= 1'b1;
                                    end
                                end
                                default: if (!is_bksp) key_drop <= 1'b1;
                            endcase
                        end
                    end
                    S_ISSUE: begin
                        key_drop <= key_valid;
                        if (op_valid && op_ready) begin
                            op_valid <= 1'b0;
                            st       <= S_WAIT;
                        end
                    end
                    default: begin
                        key_drop <= key_valid;
                        if (result_valid) begin
                            SRC   <= RESULT;
                            scnt  <= CMAX;
                            fresh <= 1'b1;
                            st    <= S_SRC;
                        end
                    end
                endcase
            end
        end
    end

    assign disp_value = (st == S_DST || st == S_ISSUE) ? DST : SRC;
    assign state      = st;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed bench for calc_operand_entry; ALU issues are checked by a scoreboard monitor.
module tb_calc_operand_entry;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        key_valid = 1'b0;
    logic [1:0]  key_kind = 2'd0;
    logic [3:0]  key_val = 4'd0;
    logic        op_ready = 1'b0;
    logic        result_valid = 1'b0;
    logic [15:0] RESULT = 16'd0;
    logic [15:0] SRC, DST, disp_value;
    logic [7:0]  ALU_OP;
    logic        op_valid, ovf, key_drop;
    logic [1:0]  state;

    calc_operand_entry #(.W(16), .MAX_DIGITS(4), .OPW(3)) dut (
        .CLK(CLK), .RESET(RESET), .key_valid(key_valid), .key_kind(key_kind),
        .key_val(key_val), .op_ready(op_ready), .result_valid(result_valid),
        .RESULT(RESULT), .SRC(SRC), .DST(DST), .ALU_OP(ALU_OP), .op_valid(op_valid),
        .disp_value(disp_value), .ovf(ovf), .key_drop(key_drop), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  op;
        int          hold;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   hc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic key(input logic [1:0] k, input logic [3:0] v);
        @(posedge CLK); #1;
        key_valid = 1'b1; key_kind = k; key_val = v;
        @(posedge CLK); #1;
        key_valid = 1'b0;
    endtask

    task automatic result(input logic [15:0] r);
        @(posedge CLK); #1;
        result_valid = 1'b1; RESULT = r;
        @(posedge CLK); #1;
        result_valid = 1'b0;
    endtask

    // Scoreboard monitor: every accepted ALU operation must match the next expected entry.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET || !op_valid) begin
                hc = 0;
            end else begin
                hc++;
                if (op_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL issue: unexpected handshake src=%0d dst=%0d", SRC, DST);
                    end else begin
                        mon_e = q.pop_front();
                        chk("issue_src", 32'(SRC), 32'(mon_e.src));
                        chk("issue_dst", 32'(DST), 32'(mon_e.dst));
                        chk("issue_op", 32'(ALU_OP), 32'(mon_e.op));
                        chk("issue_hold", 32'(hc), 32'(mon_e.hold));
                    end
                    hc = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_src", 32'(SRC), 0);
        chk("rst_dst", 32'(DST), 0);
        chk("rst_op", 32'(ALU_OP), 0);
        chk("rst_valid", 32'(op_valid), 0);
        chk("rst_state", 32'(state), 0);
        RESET = 1'b1;

        // 123 op2 45 =, ALU ready immediately
        key(2'd0, 4'd1); key(2'd0, 4'd2); key(2'd0, 4'd3);
        chk("src_123", 32'(SRC), 123);
        chk("disp_src", 32'(disp_value), 123);
        key(2'd1, 4'd2);
        chk("op_state", 32'(state), 1);
        chk("op_latch", 32'(ALU_OP), 2);
        key(2'd0, 4'd4); key(2'd0, 4'd5);
        chk("dst_45", 32'(DST), 45);
        chk("disp_dst", 32'(disp_value), 45);
        op_ready = 1'b1;
        q.push_back('{16'd123, 16'd45, 8'h02, 1});
        key(2'd2, 4'd0);
        chk("eq_valid", 32'(op_valid), 1);
        chk("eq_state", 32'(state), 2);
        @(posedge CLK); #1;
        op_ready = 1'b0;
        chk("hs_state", 32'(state), 3);
        chk("hs_valid", 32'(op_valid), 0);

        // Result chains into a new operation; ALU stalls for 5 cycles
        result(16'd168);
        chk("res_src", 32'(SRC), 168);
        chk("res_state", 32'(state), 0);
        key(2'd1, 4'd1);
        chk("chain_state", 32'(state), 1);
        chk("chain_dst", 32'(DST), 0);
        chk("chain_src", 32'(SRC), 168);
        chk("chain_op", 32'(ALU_OP), 1);
        q.push_back('{16'd168, 16'd0, 8'h01, 5});
        key(2'd2, 4'd0);
        chk("hold_valid0", 32'(op_valid), 1);
        key(2'd0, 4'd3);
        chk("hold_drop", 32'(key_drop), 1);
        chk("hold_dst", 32'(DST), 0);
        chk("hold_src", 32'(SRC), 168);
        chk("hold_valid1", 32'(op_valid), 1);
        repeat (2) @(posedge CLK);
        #1 op_ready = 1'b1;
        @(posedge CLK); #1;
        op_ready = 1'b0;
        chk("hold_state", 32'(state), 3);
        chk("hold_done", 32'(op_valid), 0);

        // A digit after a result starts a fresh SRC
        result(16'd1234);
        chk("res2_src", 32'(SRC), 1234);
        key(2'd0, 4'd7);
        chk("fresh_src", 32'(SRC), 7);
        chk("fresh_disp", 32'(disp_value), 7);
        chk("fresh_state", 32'(state), 0);

        // Digit limit and backspace
        key(2'd3, 4'd0);
        chk("clr_src", 32'(SRC), 0);
        key(2'd0, 4'd9); key(2'd0, 4'd9); key(2'd0, 4'd9); key(2'd0, 4'd9);
        chk("ovf_before", 32'(ovf), 0);
        key(2'd0, 4'd7);
        chk("ovf_pulse", 32'(ovf), 1);
        chk("ovf_src", 32'(SRC), 9999);
        @(posedge CLK); #1;
        chk("ovf_once", 32'(ovf), 0);
        key(2'd3, 4'd1);
        chk("bksp_src", 32'(SRC), 999);
        key(2'd0, 4'd12);
        chk("bad_digit_drop", 32'(key_drop), 1);
        chk("bad_digit_src", 32'(SRC), 999);

        // Clear aborts an outstanding issue
        key(2'd1, 4'd3); key(2'd0, 4'd2); key(2'd2, 4'd0);
        chk("abort_valid0", 32'(op_valid), 1);
        chk("abort_state0", 32'(state), 2);
        key(2'd3, 4'd0);
        chk("abort_valid", 32'(op_valid), 0);
        chk("abort_src", 32'(SRC), 0);
        chk("abort_dst", 32'(DST), 0);
        chk("abort_op", 32'(ALU_OP), 0);
        chk("abort_state", 32'(state), 0);

        // Asynchronous reset mid-DST entry
        key(2'd0, 4'd5); key(2'd1, 4'd4); key(2'd0, 4'd6);
        chk("pre_rst_dst", 32'(DST), 6);
        chk("pre_rst_src", 32'(SRC), 5);
        @(posedge CLK); #3;
        RESET = 1'b0;
        #1;
        chk("arst_src", 32'(SRC), 0);
        chk("arst_dst", 32'(DST), 0);
        chk("arst_op", 32'(ALU_OP), 0);
        chk("arst_valid", 32'(op_valid), 0);
        chk("arst_state", 32'(state), 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("sb_drained", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
